// File: rtl/ex_div_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_div_seq_pkg
// Purpose  : Shared encodings and constants for the EX-stage DIV/DIVU
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ex_div_seq_pkg;

    // Sequencer states (2-bit encoding).
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Start/stop request levels as seen from EX.
    localparam logic c_DIV_START = 1'b1;
    localparam logic c_DIV_STOP  = 1'b0;

    // Result-ready levels.
    localparam logic c_DIV_RESULT_READY     = 1'b1;
    localparam logic c_DIV_RESULT_NOT_READY = 1'b0;

    // Width of the {remainder, quotient} result bus.
    localparam int c_DOUBLE_REG_BUS = 64;

    // ALU operation codes that select this unit.
    localparam logic [7:0] c_EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] c_EXE_DIVU_OP = 8'b0001_1011;

endpackage
`default_nettype wire

// File: rtl/ex_div_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_div_seq_if
// Purpose  : Request/response bundle between the EX stage (master) and the
//            division sequencer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface ex_div_seq_if
    import ex_div_seq_pkg::*;
#(
    parameter int DATA_W = c_DOUBLE_REG_BUS / 2
);

    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stall_req_o;

    // EX side: issues the operation and consumes the result.
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stall_req_o
    );

    // Divider side.
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stall_req_o
    );

endinterface
`default_nettype wire

// File: rtl/ex_div_step.sv
`default_nettype none
// ============================================================================
// Module   : ex_div_step
// Purpose  : One radix-2 restoring division iteration (purely combinational).
//            Shifts the next dividend bit into the partial remainder, tries to
//            subtract the divisor and shifts the resulting quotient bit in.
// Revision : 1.0 - initial release
// ============================================================================
module ex_div_step #(
    parameter int DATA_W = 32
) (
    input  wire logic [DATA_W:0]   i_rem,
    input  wire logic [DATA_W-1:0] i_quo,
    input  wire logic [DATA_W-1:0] i_divisor,
    output logic      [DATA_W:0]   o_rem,
    output logic      [DATA_W-1:0] o_quo
);

    logic [DATA_W:0] w_shift;
    logic [DATA_W:0] w_diff;
    logic            w_unused;

    // The partial remainder never reaches the divisor, so its top bit is
    // always zero and only the low DATA_W bits take part in the shift.
    assign w_unused = i_rem[DATA_W];
    assign w_shift  = {i_rem[DATA_W-1:0], i_quo[DATA_W-1]};
    assign w_diff   = w_shift - {1'b0, i_divisor};

    // Keep the difference when it is non-negative, otherwise restore.
    always_comb begin
        o_rem = w_shift;
        o_quo = {i_quo[DATA_W-2:0], 1'b0};
        if (!w_diff[DATA_W]) begin
            o_rem = w_diff;
            o_quo = {i_quo[DATA_W-2:0], 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : ex_div_seq
// Purpose  : Multi-cycle DIV/DIVU sequencer for the EX stage. Works on operand
//            magnitudes, one quotient bit per cycle, then applies the sign
//            fix-up and presents {remainder, quotient} until EX drops start.
// Revision : 1.0 - initial release
// ============================================================================
module ex_div_seq
    import ex_div_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input wire logic    clk,
    input wire logic    rst,
    ex_div_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] c_CNT_DONE = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;

    div_state_e          r_state,       w_state_nxt;
    logic [CNT_W-1:0]    r_cnt,         w_cnt_nxt;
    logic [DATA_W:0]     r_rem,         w_rem_nxt;
    logic [DATA_W-1:0]   r_quo,         w_quo_nxt;
    logic [DATA_W-1:0]   r_divisor,     w_divisor_nxt;
    logic                r_dvd_neg,     w_dvd_neg_nxt;
    logic                r_signs_diff,  w_signs_diff_nxt;
    logic [2*DATA_W-1:0] r_result,      w_result_nxt;
    logic                r_ready,       w_ready_nxt;

    logic                w_op1_neg;
    logic                w_op2_neg;
    logic [DATA_W-1:0]   w_op1_abs;
    logic [DATA_W-1:0]   w_op2_abs;
    logic [DATA_W:0]     w_step_rem;
    logic [DATA_W-1:0]   w_step_quo;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;

    // Operand magnitudes; the most negative value maps onto itself, which is
    // exactly its unsigned magnitude.
    assign w_op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign w_op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    assign w_op1_abs = w_op1_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign w_op2_abs = w_op2_neg ? -bus.opdata2_i : bus.opdata2_i;

    // Quotient takes the sign of the operand-sign XOR, remainder the
    // dividend's sign.
    assign w_quo_fix = r_signs_diff ? -r_quo : r_quo;
    assign w_rem_fix = r_dvd_neg ? -r_rem[DATA_W-1:0] : r_rem[DATA_W-1:0];

    ex_div_step #(
        .DATA_W    (DATA_W)
    ) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    assign bus.result_o    = r_result;
    assign bus.ready_o     = r_ready;
    assign bus.stall_req_o = bus.start_i & ~r_ready & ~bus.annul_i;

    // Next-state, datapath and result decisions for every state.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_rem_nxt        = r_rem;
        w_quo_nxt        = r_quo;
        w_divisor_nxt    = r_divisor;
        w_dvd_neg_nxt    = r_dvd_neg;
        w_signs_diff_nxt = r_signs_diff;
        w_result_nxt     = r_result;
        w_ready_nxt      = r_ready;

        case (r_state)
            DivFree: begin
                w_ready_nxt  = c_DIV_RESULT_NOT_READY;
                w_result_nxt = '0;
                if (bus.start_i == c_DIV_START && !bus.annul_i) begin
                    w_cnt_nxt = c_CNT_ZERO;
                    if (bus.opdata2_i == '0) begin
                        w_state_nxt = DivByZero;
                    end else begin
                        w_state_nxt      = DivOn;
                        w_rem_nxt        = '0;
                        w_quo_nxt        = w_op1_abs;
                        w_divisor_nxt    = w_op2_abs;
                        w_dvd_neg_nxt    = w_op1_neg;
                        w_signs_diff_nxt = w_op1_neg ^ w_op2_neg;
                    end
                end
            end

            // One settle cycle so the zero result appears two edges after
            // acceptance.
            DivByZero: begin
                if (bus.annul_i) begin
                    w_state_nxt = DivFree;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else if (r_cnt == c_CNT_ZERO) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_state_nxt  = DivEnd;
                    w_cnt_nxt    = c_CNT_ZERO;
                    w_result_nxt = '0;
                    w_ready_nxt  = c_DIV_RESULT_READY;
                end
            end

            DivOn: begin
                if (bus.annul_i) begin
                    w_state_nxt = DivFree;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else if (r_cnt != c_CNT_DONE) begin
                    w_rem_nxt = w_step_rem;
                    w_quo_nxt = w_step_quo;
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_state_nxt  = DivEnd;
                    w_cnt_nxt    = c_CNT_ZERO;
                    w_result_nxt = {w_rem_fix, w_quo_fix};
                    w_ready_nxt  = c_DIV_RESULT_READY;
                end
            end

            // Hold the result until EX releases start, so a held start can
            // never launch a second operation.
            DivEnd: begin
                if (bus.start_i == c_DIV_STOP || bus.annul_i) begin
                    w_state_nxt  = DivFree;
                    w_ready_nxt  = c_DIV_RESULT_NOT_READY;
                    w_result_nxt = '0;
                end
            end

            default: begin
                w_state_nxt  = DivFree;
                w_cnt_nxt    = c_CNT_ZERO;
                w_ready_nxt  = c_DIV_RESULT_NOT_READY;
                w_result_nxt = '0;
            end
        endcase
    end

    // State and datapath registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= DivFree;
            r_cnt        <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_divisor    <= '0;
            r_dvd_neg    <= 1'b0;
            r_signs_diff <= 1'b0;
            r_result     <= '0;
            r_ready      <= c_DIV_RESULT_NOT_READY;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rem        <= w_rem_nxt;
            r_quo        <= w_quo_nxt;
            r_divisor    <= w_divisor_nxt;
            r_dvd_neg    <= w_dvd_neg_nxt;
            r_signs_diff <= w_signs_diff_nxt;
            r_result     <= w_result_nxt;
            r_ready      <= w_ready_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_div_seq
// Purpose  : Directed self-checking bench for ex_div_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_div_seq;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_div_seq_if #(.DATA_W(32)) bus ();

    ex_div_seq #(
        .DATA_W (32),
        .CNT_W  (6)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation with start held: exact latency, result, hold in END,
    // and release back to IDLE. Operands are scrambled in flight.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        logic early;
        early = 1'b0;
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        #1;
        check({tag, "/stall_accept"}, 64'(bus.stall_req_o), 64'd1);
        for (int k = 0; k <= 31; k++) begin
            tick();
            if (k == 0) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~sgn;
            end
            if (bus.ready_o !== 1'b0) early = 1'b1;
        end
        check({tag, "/ready_early"}, 64'(early), 64'd0);
        check({tag, "/stall_busy"}, 64'(bus.stall_req_o), 64'd1);
        tick();
        check({tag, "/ready_e32"}, 64'(bus.ready_o), 64'd0);
        tick();
        check({tag, "/ready_e33"}, 64'(bus.ready_o), 64'd1);
        check({tag, "/result"}, bus.result_o, exp);
        check({tag, "/stall_done"}, 64'(bus.stall_req_o), 64'd0);
        tick();
        check({tag, "/hold_ready"}, 64'(bus.ready_o), 64'd1);
        check({tag, "/hold_result"}, bus.result_o, exp);
        bus.start_i = 1'b0;
        tick();
        check({tag, "/release_ready"}, 64'(bus.ready_o), 64'd0);
        check({tag, "/release_result"}, bus.result_o, 64'd0);
    endtask

    initial begin
        logic seen;

        // Reset state, including reset winning over a start request.
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        tick();
        tick();
        check("rst/ready", 64'(bus.ready_o), 64'd0);
        check("rst/result", bus.result_o, 64'd0);
        check("rst/stall_idle", 64'(bus.stall_req_o), 64'd0);
        bus.opdata1_i = 32'd9;
        bus.opdata2_i = 32'd3;
        bus.start_i   = 1'b1;
        #1;
        check("rst/stall_start", 64'(bus.stall_req_o), 64'd1);
        tick();
        check("rst/ready_start", 64'(bus.ready_o), 64'd0);
        bus.start_i = 1'b0;
        rst         = 1'b0;
        tick();

        // 1: DIVU 100/7 = 14 r 2
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

        // 2: signed fix-ups
        run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);

        // 3: divide by zero, ready two edges after acceptance
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd5;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b1;
        #1;
        check("byzero/stall_accept", 64'(bus.stall_req_o), 64'd1);
        tick();
        check("byzero/ready_e0", 64'(bus.ready_o), 64'd0);
        check("byzero/stall_e0", 64'(bus.stall_req_o), 64'd1);
        tick();
        check("byzero/ready_e1", 64'(bus.ready_o), 64'd0);
        tick();
        check("byzero/ready_e2", 64'(bus.ready_o), 64'd1);
        check("byzero/result", bus.result_o, 64'd0);
        check("byzero/stall_done", 64'(bus.stall_req_o), 64'd0);
        bus.start_i = 1'b0;
        tick();
        check("byzero/release", 64'(bus.ready_o), 64'd0);

        // 4: annul mid-operation, then reissue
        bus.opdata1_i = 32'hFFFFFFFF;
        bus.opdata2_i = 32'h00000010;
        bus.start_i   = 1'b1;
        for (int k = 0; k <= 10; k++) tick();
        bus.annul_i = 1'b1;
        #1;
        check("annul/stall", 64'(bus.stall_req_o), 64'd0);
        tick();
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.ready_o !== 1'b0) seen = 1'b1;
        end
        check("annul/no_ready", 64'(seen), 64'd0);
        run_op("annul_reissue", 1'b0, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF);

        // start together with annul in IDLE is ignored
        bus.opdata1_i = 32'd9;
        bus.opdata2_i = 32'd4;
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 36; k++) begin
            tick();
            if (bus.ready_o !== 1'b0) seen = 1'b1;
        end
        check("start_annul/no_ready", 64'(seen), 64'd0);
        run_op("start_annul_after", 1'b0, 32'd9, 32'd4, 64'h00000001_00000002);

        // 5: signed overflow wraps; unsigned top-bit dividend
        run_op("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run_op("divu_top", 1'b0, 32'h80000000, 32'd1, 64'h00000000_80000000);

        // 6: reset mid-operation, then a fresh operation
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        for (int k = 0; k <= 14; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst/ready", 64'(bus.ready_o), 64'd0);
        check("midrst/result", bus.result_o, 64'd0);
        check("midrst/stall", 64'(bus.stall_req_o), 64'd1);
        bus.start_i = 1'b0;
        tick();
        tick();
        run_op("midrst_after", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
